// File: rtl/cache_coh_agent_pkg.sv
// Shared coherence definitions for the per-core cache agent and the bus arbiter.
// - line_state_t : MSI line state encoding (also used as write_miss_state)
// - SOURCE_*     : fill source select values carried on datasel
// - agent_st_t   : requester FSM states of the agent
package cache_coh_agent_pkg;

  typedef enum logic [1:0] {
    MODIFIED = 2'b00,
    SHARED   = 2'b01,
    INVALID  = 2'b10
  } line_state_t;

  localparam logic SOURCE_DMEM       = 1'b0;
  localparam logic SOURCE_OTHER_PROC = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    FILL
  } agent_st_t;

endpackage

// File: rtl/cache_coh_agent_coh_line_array.sv
// Direct-mapped tag/state/data storage for one coherence agent.
// Ports:
//   clk, rst_n                 clock, async active-low reset (all lines INVALID)
//   cpu_idx -> cpu_tag/state/data   combinational CPU-side lookup
//   cpu_we, cpu_wtag/wstate/wdata   CPU-side full-line write (hit update or fill)
//   snp_idx -> snp_tag/state/data   combinational snoop-side lookup
//   snp_we, snp_wstate              snoop-side state-only write
module coh_line_array
  import cache_coh_agent_pkg::*;
#(
  parameter int IDX_W  = 2,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  cpu_idx,
  output logic [TAG_W-1:0]  cpu_tag,
  output line_state_t       cpu_state,
  output logic [DATA_W-1:0] cpu_data,
  input  logic              cpu_we,
  input  logic [TAG_W-1:0]  cpu_wtag,
  input  line_state_t       cpu_wstate,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [IDX_W-1:0]  snp_idx,
  output logic [TAG_W-1:0]  snp_tag,
  output line_state_t       snp_state,
  output logic [DATA_W-1:0] snp_data,
  input  logic              snp_we,
  input  line_state_t       snp_wstate
);

  localparam int NUM_LINES = 1 << IDX_W;

  logic [TAG_W-1:0]  tag_q   [NUM_LINES];
  line_state_t       state_q [NUM_LINES];
  logic [DATA_W-1:0] data_q  [NUM_LINES];

  assign cpu_tag   = tag_q[cpu_idx];
  assign cpu_state = state_q[cpu_idx];
  assign cpu_data  = data_q[cpu_idx];
  assign snp_tag   = tag_q[snp_idx];
  assign snp_state = state_q[snp_idx];
  assign snp_data  = data_q[snp_idx];

  // The CPU-side write is issued after the snoop write so that, on the same
  // index in the same cycle, a fill overwrites whatever the snoop did.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        tag_q[i]   <= '0;
        state_q[i] <= INVALID;
        data_q[i]  <= '0;
      end
    end else begin
      if (snp_we) begin
        state_q[snp_idx] <= snp_wstate;
      end
      if (cpu_we) begin
        tag_q[cpu_idx]   <= cpu_wtag;
        state_q[cpu_idx] <= cpu_wstate;
        data_q[cpu_idx]  <= cpu_wdata;
      end
    end
  end

endmodule

// File: rtl/cache_coh_agent.sv
// Per-core MSI coherence agent for a direct-mapped d-cache.
// Requester: detects misses/upgrades, raises read_miss/write_miss with tag_in and
// write_miss_state, waits for grant, takes the fill (datasel: DMEM or peer),
// writes back a dirty victim (wb_*), then acks the CPU (cpu_ack/cpu_rdata).
// Responder: answers search with registered search_found/snoop_rdata and applies
// invalidate_tag on snoop_addr.
// Optional macro COH_STATS_EN adds saturating counters snoop_hit_cnt and inval_cnt.
module cache_coh_agent
  import cache_coh_agent_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int IDX_W    = 2,
  parameter int DATA_W   = 16,
  parameter int FILL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              read_miss,
  output logic              write_miss,
  output logic [1:0]        write_miss_state,
  output logic [ADDR_W-1:0] tag_in,
  input  logic              grant,
  input  logic              datasel,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic [DATA_W-1:0] peer_rdata,
  input  logic              search,
  input  logic              invalidate_tag,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              search_found,
  output logic [DATA_W-1:0] snoop_rdata,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data
`ifdef COH_STATS_EN
  ,
  output logic [15:0]       snoop_hit_cnt,
  output logic [15:0]       inval_cnt
`endif
);

  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int CNT_W = 4;

  agent_st_t         state_q, state_d;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] fill_q;
  logic [DATA_W-1:0] fill_word;
  logic              miss_wr_q;

  logic [IDX_W-1:0]  req_idx, snp_idx;
  logic [TAG_W-1:0]  req_tag, snp_req_tag;
  logic [TAG_W-1:0]  arr_tag, snp_tag;
  line_state_t       arr_state, snp_state;
  logic [DATA_W-1:0] arr_data, snp_data;
  logic              arr_we, snp_we;
  line_state_t       arr_wstate, snp_wstate;
  logic [DATA_W-1:0] arr_wdata;

  logic req_valid, tag_hit, rd_hit, wr_hit_m, need_miss, victim_dirty, snp_hit;

  assign req_idx     = cpu_addr[IDX_W-1:0];
  assign req_tag     = cpu_addr[ADDR_W-1:IDX_W];
  assign snp_idx     = snoop_addr[IDX_W-1:0];
  assign snp_req_tag = snoop_addr[ADDR_W-1:IDX_W];

  coh_line_array #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W),
    .DATA_W(DATA_W)
  ) u_lines (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_idx   (req_idx),
    .cpu_tag   (arr_tag),
    .cpu_state (arr_state),
    .cpu_data  (arr_data),
    .cpu_we    (arr_we),
    .cpu_wtag  (req_tag),
    .cpu_wstate(arr_wstate),
    .cpu_wdata (arr_wdata),
    .snp_idx   (snp_idx),
    .snp_tag   (snp_tag),
    .snp_state (snp_state),
    .snp_data  (snp_data),
    .snp_we    (snp_we),
    .snp_wstate(snp_wstate)
  );

  // The CPU holds its request through the ack cycle, so a request seen while
  // cpu_ack is high is the one just completed and must not be served twice.
  assign req_valid    = (cpu_rd || cpu_wr) && !cpu_ack;
  assign tag_hit      = (arr_tag == req_tag) && (arr_state != INVALID);
  assign rd_hit       = req_valid && cpu_rd && tag_hit;
  assign wr_hit_m     = req_valid && cpu_wr && tag_hit && (arr_state == MODIFIED);
  assign need_miss    = req_valid && !rd_hit && !wr_hit_m;
  assign victim_dirty = (arr_state == MODIFIED) && (arr_tag != req_tag);
  assign snp_hit      = (snp_tag == snp_req_tag) && (snp_state != INVALID);

  always_comb begin
    fill_word = dmem_rdata;
    case (datasel)
      SOURCE_DMEM:       fill_word = dmem_rdata;
      SOURCE_OTHER_PROC: fill_word = peer_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (need_miss) state_d = REQ;
      REQ:  if (grant) state_d = XFER;
      XFER: if (count_q == '0) state_d = FILL;
      FILL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // write_miss_state follows the live line state, so a snoop invalidate during
  // an upgrade turns it into a full write miss from INVALID.
  always_comb begin
    read_miss        = 1'b0;
    write_miss       = 1'b0;
    tag_in           = '0;
    write_miss_state = 2'b00;
    if (state_q == REQ || state_q == XFER) begin
      read_miss        = !miss_wr_q;
      write_miss       = miss_wr_q;
      tag_in           = cpu_addr;
      write_miss_state = arr_state;
    end
  end

  always_comb begin
    arr_we     = 1'b0;
    arr_wstate = MODIFIED;
    arr_wdata  = cpu_wdata;
    if (state_q == IDLE && wr_hit_m) begin
      arr_we = 1'b1;
    end else if (state_q == FILL) begin
      arr_we = 1'b1;
      if (!miss_wr_q) begin
        arr_wstate = SHARED;
        arr_wdata  = fill_q;
      end
    end
  end

  // An invalidate takes precedence over the M->S downgrade of a search hit.
  always_comb begin
    snp_we     = 1'b0;
    snp_wstate = SHARED;
    if (invalidate_tag && snp_hit) begin
      snp_we     = 1'b1;
      snp_wstate = INVALID;
    end else if (search && snp_hit && snp_state == MODIFIED) begin
      snp_we = 1'b1;
    end
  end

  // Writes take cpu_wdata for the whole word, so fill data only matters on reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      fill_q    <= '0;
      miss_wr_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (need_miss) miss_wr_q <= cpu_wr;
        REQ:  if (grant) count_q <= CNT_W'(FILL_LAT - 1);
        XFER: begin
          if (count_q == '0) begin
            if (!miss_wr_q) fill_q <= fill_word;
          end else begin
            count_q <= count_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      wb_valid  <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
    end else begin
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      wb_valid  <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      if (state_q == IDLE && (rd_hit || wr_hit_m)) begin
        cpu_ack <= 1'b1;
        if (rd_hit) cpu_rdata <= arr_data;
      end
      if (state_q == FILL) begin
        cpu_ack <= 1'b1;
        if (!miss_wr_q) cpu_rdata <= fill_q;
      end
      if (state_q == REQ && grant && victim_dirty) begin
        wb_valid <= 1'b1;
        wb_addr  <= {arr_tag, req_idx};
        wb_data  <= arr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      search_found <= 1'b0;
      snoop_rdata  <= '0;
    end else begin
      search_found <= search && snp_hit;
      snoop_rdata  <= (search && snp_hit) ? snp_data : '0;
    end
  end

`ifdef COH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snoop_hit_cnt <= '0;
      inval_cnt     <= '0;
    end else begin
      if (search && snp_hit && snoop_hit_cnt != 16'hFFFF)
        snoop_hit_cnt <= snoop_hit_cnt + 16'd1;
      if (invalidate_tag && snp_hit && inval_cnt != 16'hFFFF)
        inval_cnt <= inval_cnt + 16'd1;
    end
  end
`endif

endmodule
